// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined rotate/shift unit, one log-stage per shift-amount bit
module shifter_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_b,
    input  logic             in_rot,
    input  logic             in_left,
    input  logic             in_sign,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic             v_q     [SHW];
    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   b_q     [SHW];
    logic             rot_q   [SHW];
    logic             left_q  [SHW];
    logic             sign_q  [SHW];
    logic             carry_q [SHW];
    logic [TAG_W-1:0] tag_q   [SHW];
    logic             zero_q;

    logic             src_v     [SHW];
    logic [WIDTH-1:0] src_data  [SHW];
    logic [SHW-1:0]   src_b     [SHW];
    logic             src_rot   [SHW];
    logic             src_left  [SHW];
    logic             src_sign  [SHW];
    logic             src_carry [SHW];
    logic [TAG_W-1:0] src_tag   [SHW];

    logic [WIDTH-1:0] nxt_data  [SHW];
    logic             nxt_carry [SHW];

    logic stall;

    assign stall    = v_q[SHW-1] && !out_ready;
    assign in_ready = !stall;

    // Stage 0 reads the input port; stage k reads stage k-1's register.
    // The sign bit is stored already qualified by direction and rotate.
    always_comb begin
        src_v[0]     = in_valid;
        src_data[0]  = in_a;
        src_b[0]     = in_b;
        src_rot[0]   = in_rot;
        src_left[0]  = in_left;
        src_sign[0]  = in_sign && !in_left && !in_rot;
        src_carry[0] = 1'b0;
        src_tag[0]   = in_tag;
        for (int k = 1; k < SHW; k++) begin
            src_v[k]     = v_q[k-1];
            src_data[k]  = data_q[k-1];
            src_b[k]     = b_q[k-1];
            src_rot[k]   = rot_q[k-1];
            src_left[k]  = left_q[k-1];
            src_sign[k]  = sign_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_tag[k]   = tag_q[k-1];
        end
    end

    // Carry is the last bit pushed past the edge; for rotates that is the wrapped bit.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            logic [WIDTH-1:0] d;
            logic [WIDTH-1:0] lo;
            logic [WIDTH-1:0] hi;
            logic [WIDTH-1:0] fill;
            logic [WIDTH-1:0] cr;
            logic [SHW-1:0]   bsel;
            int               amt;
            amt  = 1 << k;
            d    = src_data[k];
            lo   = d >> (WIDTH - amt);
            hi   = d << (WIDTH - amt);
            cr   = d >> (amt - 1);
            bsel = src_b[k] >> k;
            fill = '0;
            nxt_data[k]  = d;
            nxt_carry[k] = src_carry[k];
            if (bsel[0]) begin
                if (src_left[k]) begin
                    nxt_data[k]  = (d << amt) | (src_rot[k] ? lo : '0);
                    nxt_carry[k] = lo[0];
                end else begin
                    if (src_rot[k])
                        fill = hi;
                    else if (src_sign[k])
                        fill = ~({WIDTH{1'b1}} >> amt) & {WIDTH{d[WIDTH-1]}};
                    nxt_data[k]  = (d >> amt) | fill;
                    nxt_carry[k] = cr[0];
                end
            end
        end
    end

    // Payload only loads behind a valid op, so idle inputs never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                v_q[k]     <= 1'b0;
                data_q[k]  <= '0;
                b_q[k]     <= '0;
                rot_q[k]   <= 1'b0;
                left_q[k]  <= 1'b0;
                sign_q[k]  <= 1'b0;
                carry_q[k] <= 1'b0;
                tag_q[k]   <= '0;
            end
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < SHW; k++) begin
                v_q[k] <= src_v[k];
                if (src_v[k]) begin
                    data_q[k]  <= nxt_data[k];
                    b_q[k]     <= src_b[k];
                    rot_q[k]   <= src_rot[k];
                    left_q[k]  <= src_left[k];
                    sign_q[k]  <= src_sign[k];
                    carry_q[k] <= nxt_carry[k];
                    tag_q[k]   <= src_tag[k];
                end
            end
            if (src_v[SHW-1])
                zero_q <= (nxt_data[SHW-1] == '0);
        end
    end

    assign out_valid = v_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_carry = carry_q[SHW-1];
    assign out_zero  = zero_q;
    assign out_tag   = tag_q[SHW-1];

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - directed self-checking bench for shifter_pipe
module tb_shifter_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [2:0] in_b;
    logic       in_rot;
    logic       in_left;
    logic       in_sign;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_zero;
    logic [3:0] out_tag;

    int checks = 0;
    int errors = 0;

    shifter_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rot    (in_rot),
        .in_left   (in_left),
        .in_sign   (in_sign),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready high and check the result appears exactly three cycles later.
    task automatic run_op(input string nm, input logic [7:0] a, input logic [2:0] b,
                          input logic rot, input logic left, input logic sign,
                          input logic [3:0] tag, input logic [7:0] ed, input logic ec);
        in_valid = 1'b1; in_a = a; in_b = b; in_rot = rot; in_left = left; in_sign = sign; in_tag = tag;
        tick();
        in_valid = 1'b0; in_a = 8'h5A; in_b = 3'd5;
        tick();
        check({nm, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_data"},  32'(out_data),  32'(ed));
        check({nm, "_carry"}, 32'(out_carry), 32'(ec));
        check({nm, "_zero"},  32'(out_zero),  32'(ed == 8'h00));
        check({nm, "_tag"},   32'(out_tag),   32'(tag));
    endtask

    logic [7:0] s_a   [8];
    logic [2:0] s_b   [8];
    logic [7:0] s_exp [8];
    logic       s_c   [8];
    logic [7:0] tmp;
    logic [7:0] snap_data;
    logic [3:0] snap_tag;
    logic       stalled_prev;
    logic       acc;
    int         idx;
    int         rx;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_rot = 1'b0;
        in_left = 1'b0; in_sign = 1'b0; in_tag = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_carry", 32'(out_carry), 32'd0);
        check("rst_zero",  32'(out_zero),  32'd0);
        check("rst_tag",   32'(out_tag),   32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        run_op("rotl3", 8'b10000111, 3'd3, 1'b1, 1'b1, 1'b0, 4'h1, 8'b00111100, 1'b0);
        run_op("rotr2", 8'b10000111, 3'd2, 1'b1, 1'b0, 1'b0, 4'h2, 8'b11100001, 1'b1);
        run_op("asr3",  8'b10000111, 3'd3, 1'b0, 1'b0, 1'b1, 4'h3, 8'b11110000, 1'b1);
        run_op("lsr3",  8'b10000111, 3'd3, 1'b0, 1'b0, 1'b0, 4'h4, 8'b00010000, 1'b1);
        run_op("lsl1",  8'b10000111, 3'd1, 1'b0, 1'b1, 1'b0, 4'h5, 8'b00001110, 1'b1);
        run_op("lsr1z", 8'b00000001, 3'd1, 1'b0, 1'b0, 1'b0, 4'h6, 8'b00000000, 1'b1);
        run_op("rotl0", 8'hA5,       3'd0, 1'b1, 1'b1, 1'b0, 4'h7, 8'hA5,       1'b0);
        run_op("asr0",  8'h80,       3'd0, 1'b0, 1'b0, 1'b1, 4'h8, 8'h80,       1'b0);
        run_op("lsl7",  8'hFF,       3'd7, 1'b0, 1'b1, 1'b0, 4'h9, 8'h80,       1'b1);
        run_op("asr7",  8'h80,       3'd7, 1'b0, 1'b0, 1'b1, 4'hA, 8'hFF,       1'b0);
        run_op("lsl1s", 8'h81,       3'd1, 1'b0, 1'b1, 1'b1, 4'hB, 8'h02,       1'b1);
        tick();

        // Streaming: eight logical-left ops back to back with a five-cycle stall.
        for (int i = 0; i < 8; i++) begin
            s_a[i] = 8'hC3 ^ 8'(i * 17);
            s_b[i] = 3'(i);
            s_exp[i] = s_a[i] << s_b[i];
            tmp = s_a[i] >> (8 - i);
            s_c[i] = (i == 0) ? 1'b0 : tmp[0];
        end
        idx = 0; rx = 0; stalled_prev = 1'b0;
        snap_data = '0; snap_tag = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 5 && c <= 9);
            if (idx < 8) begin
                in_valid = 1'b1; in_a = s_a[idx]; in_b = s_b[idx];
                in_rot = 1'b0; in_left = 1'b1; in_sign = 1'b0; in_tag = 4'(idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (stalled_prev) begin
                    check("stall_data_hold", 32'(out_data), 32'(snap_data));
                    check("stall_tag_hold",  32'(out_tag),  32'(snap_tag));
                end
                snap_data = out_data; snap_tag = out_tag;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (rx < 8) begin
                    check("stream_tag",   32'(out_tag),   32'(rx));
                    check("stream_data",  32'(out_data),  32'(s_exp[rx]));
                    check("stream_carry", 32'(out_carry), 32'(s_c[rx]));
                end
                rx++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        check("stream_rx_count", 32'(rx), 32'd8);
        check("stream_tx_count", 32'(idx), 32'd8);

        // Reset with three ops in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 8'h11 + 8'(i); in_b = 3'd1;
            in_rot = 1'b0; in_left = 1'b1; in_sign = 1'b0; in_tag = 4'hC + 4'(i);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data",  32'(out_data),  32'd0);
        check("midrst_carry", 32'(out_carry), 32'd0);
        check("midrst_zero",  32'(out_zero),  32'd0);
        check("midrst_tag",   32'(out_tag),   32'd0);
        in_a = 8'hFF; in_b = 3'd7; in_tag = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        check("idle_data_untouched", 32'(out_data), 32'd0);
        run_op("after_rst", 8'h0F, 3'd1, 1'b1, 1'b0, 1'b0, 4'h3, 8'h87, 1'b1);
        tick();
        check("after_rst_alone", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Pipelined, parametrised successor to the combinational `shifter`.
- Performs rotate, logical and arithmetic shifts in left and right directions, with per-transaction mode bits.
- Uses one log-stage per shift-amount bit and valid/ready handshakes on both sides.
- Adds carry-out and zero flags, a side-band tag and backpressure; sits between the operand-issue logic and the ALU writeback stage.

Parameters:
- WIDTH, 8, data width; power of two, at least 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  WIDTH  operand.
- in_b  in  SHW  shift amount, 0..WIDTH-1.
- in_rot  in  1  1 = rotate; overrides in_sign.
- in_left  in  1  1 = left, 0 = right.
- in_sign  in  1  1 = arithmetic right shift (MSB fill). Ignored when in_left=1 or in_rot=1.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted/rotated result.
- out_carry  out  1  carry flag, defined under Behaviour.
- out_zero  out  1  1 when out_data == 0.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: when rst_n=0 at a clk edge, every stage valid bit clears. Also out_valid=0, out_data=0, out_carry=0, out_zero=0, out_tag=0. Reset mid-operation discards all in-flight operations with no partial output.
- Pipeline structure: SHW stages. Stage k shifts/rotates by 2^k when b[k]=1, otherwise passes the value through. Stage SHW-1 is the output register.
- Latency: exactly SHW cycles from accepted input to out_valid when not stalled (3 for WIDTH=8). Throughput is one operation per cycle.
- Handshake:
  - An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready. While stalled, all stages hold, and out_data, out_carry, out_zero and out_tag remain stable.
  - in_ready = !stall, combinational from out_ready.
  - Bubbles (stage valid=0) advance normally; no bubble collapsing.
- Mode and fill rules:
  - Left shift zero-fills.
  - Right shift fills with a[WIDTH-1] if sign=1, otherwise with 0.
  - Rotate fills with wrapped bits.
- Mode bits, b, the tag and the carry-in-progress travel with each operation through every stage.
- Carry (b>0):
  - Logical/arithmetic left: a[WIDTH-b].
  - Logical/arithmetic right: a[b-1].
  - Rotate left: out_data[0].
  - Rotate right: out_data[WIDTH-1].
- Carry (b=0): out_carry=0 and out_data=a for all modes.
- out_zero is computed from the final data; it may be registered with it or derived combinationally from out_data, but must be valid whenever out_valid=1.
- Simultaneous events:
  - Input accepted in the same cycle as the output drains: both transfers occur and the pipe advances.
  - Input presented while stalled: not accepted; the producer must hold in_valid and its operands.
- Values on in_* when in_valid=0 must not affect any output.

Test Plan:
- WIDTH=8, no stall, a=8'b10000111, b=3, rot=1, left=1 -> after 3 cycles out_data=8'b00111100, carry=0, zero=0.
- a=8'b10000111, b=2, rot=1, left=0 -> out_data=8'b11100001, carry=1.
- a=8'b10000111, b=3:
  - left=0, sign=1 -> 8'b11110000, carry=1.
  - left=0, sign=0 -> 8'b00010000, carry=1.
  - left=1, b=1 -> 8'b00001110, carry=1.
- a=8'b00000001, b=1, lsr -> out_data=0, zero=1, carry=1. Any mode with b=0 -> out_data=a, carry=0.
- Back-to-back stream of 8 ops with tags 0..7; hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, no op lost or duplicated, tags emerge in order, outputs stable while stalled.
- Assert rst_n=0 for one cycle with 3 ops in flight -> next cycle out_valid=0 and all outputs 0. A new op issued after reset emerges alone 3 cycles later.
